// File: rtl/alu_stack_ctrl_if.sv
// Bundle between the bytecode sequencer, its decoder, the operand stack
// and the shared combinational ALU.
//
// Handshake: an opcode transfers on a rising edge where op_valid and
// op_ready are both high. The decoder holds op_valid and op_code steady
// until it sees op_ready; the sequencer ignores op_valid while busy.
// stack_pop and stack_push are single-cycle strobes, never high together.
interface alu_stack_ctrl_if;
  logic        op_valid;
  logic [3:0]  op_code;
  logic        op_ready;
  logic        stack_empty;
  logic [31:0] stack_top;
  logic        stack_pop;
  logic        stack_push;
  logic [31:0] stack_push_data;
  logic [31:0] alu_operand_a;
  logic [31:0] alu_operand_b;
  logic [3:0]  alu_op_select;
  logic [31:0] alu_result;
  logic        done;
  logic        error;
  logic [1:0]  error_cause;

  // Environment side: decoder, operand stack and ALU.
  modport master (
    output op_valid, op_code, stack_empty, stack_top, alu_result,
    input  op_ready, stack_pop, stack_push, stack_push_data,
           alu_operand_a, alu_operand_b, alu_op_select,
           done, error, error_cause
  );

  // Sequencer side.
  modport slave (
    input  op_valid, op_code, stack_empty, stack_top, alu_result,
    output op_ready, stack_pop, stack_push, stack_push_data,
           alu_operand_a, alu_operand_b, alu_op_select,
           done, error, error_cause
  );
endinterface

// File: rtl/alu_stack_ctrl.sv
// alu_stack_ctrl: pops operands from the operand stack, drives the shared
// ALU and pushes the result back, one opcode at a time.
// Optional feature macro: ALU_STACK_CTRL_ILLEGAL_TRAP_EN
//   defined   -> unsupported opcodes raise error with cause 2'b10
//   undefined -> unsupported opcodes retire as a no-op with a done pulse
module alu_stack_ctrl (
  input  logic             clk,
  input  logic             rst,
  alu_stack_ctrl_if.slave  bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP1 = 3'd1,
    S_POP2 = 3'd2,
    S_EXEC = 3'd3,
    S_PUSH = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_UNDERFLOW = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'b10;

  state_t      state;
  logic        op_ready_q;
  logic        push_q;
  logic [31:0] push_data_q;
  logic [31:0] operand_a_q;
  logic [31:0] operand_b_q;
  logic [3:0]  op_select_q;
  logic        done_q;
  logic        error_q;
  logic [1:0]  cause_q;

  function automatic logic is_binary(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b1100,
      4'b1101, 4'b1111, 4'b1000, 4'b1001: is_binary = 1'b1;
      default:                            is_binary = 1'b0;
    endcase
  endfunction

  function automatic logic is_unary(input logic [3:0] code);
    is_unary = (code == 4'b0101);
  endfunction

  // Sequencer FSM with registered outputs; done/error/push are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_ready_q  <= 1'b1;
      push_q      <= 1'b0;
      push_data_q <= '0;
      operand_a_q <= '0;
      operand_b_q <= '0;
      op_select_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cause_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      push_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.op_valid) begin
            op_select_q <= bus.op_code;
            if (is_binary(bus.op_code) || is_unary(bus.op_code)) begin
              state      <= S_POP1;
              op_ready_q <= 1'b0;
            end else begin
`ifdef ALU_STACK_CTRL_ILLEGAL_TRAP_EN
              error_q <= 1'b1;
              cause_q <= CAUSE_ILLEGAL;
`else
              done_q  <= 1'b1;
`endif
            end
          end
        end
        S_POP1: begin
          if (bus.stack_empty) begin
            error_q    <= 1'b1;
            cause_q    <= CAUSE_UNDERFLOW;
            state      <= S_IDLE;
            op_ready_q <= 1'b1;
          end else if (is_unary(op_select_q)) begin
            operand_a_q <= bus.stack_top;
            operand_b_q <= '0;
            state       <= S_EXEC;
          end else begin
            // Top of stack is the right-hand operand.
            operand_b_q <= bus.stack_top;
            state       <= S_POP2;
          end
        end
        S_POP2: begin
          if (bus.stack_empty) begin
            // The operand already popped is lost; the stack is not repaired.
            error_q    <= 1'b1;
            cause_q    <= CAUSE_UNDERFLOW;
            state      <= S_IDLE;
            op_ready_q <= 1'b1;
          end else begin
            operand_a_q <= bus.stack_top;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          push_data_q <= bus.alu_result;
          push_q      <= 1'b1;
          done_q      <= 1'b1;
          state       <= S_PUSH;
        end
        S_PUSH: begin
          state      <= S_IDLE;
          op_ready_q <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          op_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Pop must be suppressed in the same cycle the stack reports empty,
  // so it is decoded from the state register and stack_empty directly.
  assign bus.stack_pop = ((state == S_POP1) || (state == S_POP2)) && !bus.stack_empty;

  assign bus.op_ready        = op_ready_q;
  assign bus.stack_push      = push_q;
  assign bus.stack_push_data = push_data_q;
  assign bus.alu_operand_a   = operand_a_q;
  assign bus.alu_operand_b   = operand_b_q;
  assign bus.alu_op_select   = op_select_q;
  assign bus.done            = done_q;
  assign bus.error           = error_q;
  assign bus.error_cause     = cause_q;
  assign dbg_state           = state;

endmodule

// File: tb/tb_alu_stack_ctrl.sv
// Directed bench for alu_stack_ctrl with a behavioural operand stack and ALU.
module tb_alu_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  dbg_state;

  alu_stack_ctrl_if bus ();

  alu_stack_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- stack and ALU models ----------------
  logic [31:0] mem [16];
  logic [4:0]  sp = '0;
  logic        ld_en  = 1'b0;
  logic        ld_clr = 1'b0;
  logic [31:0] ld_val = '0;

  always_comb begin
    bus.stack_empty = (sp == 5'd0);
    bus.stack_top   = (sp == 5'd0) ? 32'h0 : mem[sp - 5'd1];
  end

  always @(posedge clk) begin
    if (ld_clr) begin
      sp <= '0;
    end else if (ld_en) begin
      mem[sp] <= ld_val;
      sp      <= sp + 5'd1;
    end else if (bus.stack_pop) begin
      sp <= sp - 5'd1;
    end else if (bus.stack_push) begin
      mem[sp] <= bus.stack_push_data;
      sp      <= sp + 5'd1;
    end
  end

  always_comb begin
    case (bus.alu_op_select)
      4'b0000: bus.alu_result = bus.alu_operand_a + bus.alu_operand_b;
      4'b0001: bus.alu_result = bus.alu_operand_a - bus.alu_operand_b;
      4'b0010: bus.alu_result = bus.alu_operand_a * bus.alu_operand_b;
      4'b1100: bus.alu_result = bus.alu_operand_a << bus.alu_operand_b[4:0];
      4'b1101: bus.alu_result = $unsigned($signed(bus.alu_operand_a) >>> bus.alu_operand_b[4:0]);
      4'b1111: bus.alu_result = bus.alu_operand_a & bus.alu_operand_b;
      4'b1000: bus.alu_result = bus.alu_operand_a | bus.alu_operand_b;
      4'b1001: bus.alu_result = bus.alu_operand_a ^ bus.alu_operand_b;
      4'b0101: bus.alu_result = 32'h0 - bus.alu_operand_a;
      default: bus.alu_result = 32'h0;
    endcase
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard: every push must match the next expected result.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("pop_push_exclusive", {31'b0, bus.stack_pop & bus.stack_push}, 32'h0);
      if (bus.stack_push === 1'b1) begin
        check("push_expected", {31'b0, exp_q.size() != 0}, 32'h1);
        if (exp_q.size() != 0) check("push_data_sb", bus.stack_push_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stack();
    ld_clr = 1'b1;
    tick();
    ld_clr = 1'b0;
  endtask

  task automatic preload(input logic [31:0] v);
    ld_en  = 1'b1;
    ld_val = v;
    tick();
    ld_en  = 1'b0;
  endtask

  // Offers one opcode while the DUT is idle; returns in cycle 1.
  task automatic issue(input logic [3:0] code);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_op_ready"},  {31'b0, bus.op_ready},   32'h1);
    check({tag, "_pop"},       {31'b0, bus.stack_pop},  32'h0);
    check({tag, "_push"},      {31'b0, bus.stack_push}, 32'h0);
    check({tag, "_push_data"}, bus.stack_push_data,     32'h0);
    check({tag, "_opa"},       bus.alu_operand_a,       32'h0);
    check({tag, "_opb"},       bus.alu_operand_b,       32'h0);
    check({tag, "_sel"},       {28'b0, bus.alu_op_select}, 32'h0);
    check({tag, "_done"},      {31'b0, bus.done},       32'h0);
    check({tag, "_error"},     {31'b0, bus.error},      32'h0);
    check({tag, "_cause"},     {30'b0, bus.error_cause}, 32'h0);
    check({tag, "_state"},     {29'b0, dbg_state},      32'h0);
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    rst          = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_code  = 4'h0;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // ISUB on [7, 3]: 7 - 3 = 4
    clear_stack(); preload(32'd7); preload(32'd3);
    exp_q.push_back(32'h4);
    issue(4'b0001);
    check("isub_c1_pop",   {31'b0, bus.stack_pop}, 32'h1);
    check("isub_c1_ready", {31'b0, bus.op_ready},  32'h0);
    tick();
    check("isub_c2_pop",   {31'b0, bus.stack_pop}, 32'h1);
    check("isub_c2_state", {29'b0, dbg_state},     32'h2);
    tick();
    check("isub_c3_pop",   {31'b0, bus.stack_pop}, 32'h0);
    check("isub_c3_opa",   bus.alu_operand_a,      32'd7);
    check("isub_c3_opb",   bus.alu_operand_b,      32'd3);
    tick();
    check("isub_c4_push",  {31'b0, bus.stack_push}, 32'h1);
    check("isub_c4_done",  {31'b0, bus.done},       32'h1);
    check("isub_c4_data",  bus.stack_push_data,     32'h4);
    check("isub_c4_ready", {31'b0, bus.op_ready},   32'h0);
    tick();
    check("isub_c5_ready", {31'b0, bus.op_ready},   32'h1);
    check("isub_c5_done",  {31'b0, bus.done},       32'h0);
    check("isub_c5_depth", {27'b0, sp},             32'h1);

    // INEG on [5]: -5
    clear_stack(); preload(32'd5);
    exp_q.push_back(32'hFFFF_FFFB);
    issue(4'b0101);
    check("ineg_c1_pop",   {31'b0, bus.stack_pop}, 32'h1);
    tick();
    check("ineg_c2_state", {29'b0, dbg_state},     32'h3);
    check("ineg_c2_opa",   bus.alu_operand_a,      32'd5);
    check("ineg_c2_opb",   bus.alu_operand_b,      32'd0);
    tick();
    check("ineg_c3_push",  {31'b0, bus.stack_push}, 32'h1);
    check("ineg_c3_done",  {31'b0, bus.done},       32'h1);
    check("ineg_c3_data",  bus.stack_push_data,     32'hFFFF_FFFB);
    tick();
    check("ineg_c4_ready", {31'b0, bus.op_ready},   32'h1);

    // IADD on [1]: underflow in POP2
    clear_stack(); preload(32'd1);
    issue(4'b0000);
    check("uf2_c1_pop",    {31'b0, bus.stack_pop}, 32'h1);
    tick();
    check("uf2_c2_pop",    {31'b0, bus.stack_pop}, 32'h0);
    check("uf2_c2_error",  {31'b0, bus.error},     32'h0);
    tick();
    check("uf2_c3_error",  {31'b0, bus.error},       32'h1);
    check("uf2_c3_cause",  {30'b0, bus.error_cause}, 32'h1);
    check("uf2_c3_done",   {31'b0, bus.done},        32'h0);
    check("uf2_c3_ready",  {31'b0, bus.op_ready},    32'h1);
    check("uf2_c3_state",  {29'b0, dbg_state},       32'h0);
    tick();
    check("uf2_c4_error",  {31'b0, bus.error},       32'h0);
    check("uf2_c4_cause",  {30'b0, bus.error_cause}, 32'h1);
    check("uf2_c4_depth",  {27'b0, sp},              32'h0);

    // IMUL on empty stack: underflow in POP1, no pop at all
    clear_stack();
    issue(4'b0010);
    check("uf1_c1_pop",    {31'b0, bus.stack_pop}, 32'h0);
    check("uf1_c1_state",  {29'b0, dbg_state},     32'h1);
    tick();
    check("uf1_c2_error",  {31'b0, bus.error},       32'h1);
    check("uf1_c2_cause",  {30'b0, bus.error_cause}, 32'h1);
    check("uf1_c2_ready",  {31'b0, bus.op_ready},    32'h1);

    // Unsupported opcode 0011
    clear_stack(); preload(32'd9);
    issue(4'b0011);
    check("ill_c1_pop",    {31'b0, bus.stack_pop}, 32'h0);
    check("ill_c1_push",   {31'b0, bus.stack_push}, 32'h0);
    check("ill_c1_ready",  {31'b0, bus.op_ready},   32'h1);
    check("ill_c1_state",  {29'b0, dbg_state},      32'h0);
`ifdef ALU_STACK_CTRL_ILLEGAL_TRAP_EN
    check("ill_c1_error",  {31'b0, bus.error},       32'h1);
    check("ill_c1_cause",  {30'b0, bus.error_cause}, 32'h2);
    check("ill_c1_done",   {31'b0, bus.done},        32'h0);
`else
    check("ill_c1_done",   {31'b0, bus.done},        32'h1);
    check("ill_c1_error",  {31'b0, bus.error},       32'h0);
    check("ill_c1_cause",  {30'b0, bus.error_cause}, 32'h1);
`endif
    tick();
    check("ill_c2_done",   {31'b0, bus.done},  32'h0);
    check("ill_c2_error",  {31'b0, bus.error}, 32'h0);
    check("ill_c2_depth",  {27'b0, sp},        32'h1);

    // Reset during EXEC of IMUL 0x10000 * 2: push is dropped
    clear_stack(); preload(32'h0001_0000); preload(32'd2);
    issue(4'b0010);
    tick();
    tick();
    check("rst_c3_state",  {29'b0, dbg_state},   32'h3);
    check("rst_c3_opa",    bus.alu_operand_a,    32'h0001_0000);
    rst = 1'b1;
    tick();
    check_reset_vals("rst_exec");
    check("rst_depth",     {27'b0, sp},          32'h0);
    rst = 1'b0;
    tick();

    // Back-to-back ISHL with op_valid held: [3, 1, 33] -> [3, 2] -> [12]
    clear_stack(); preload(32'd3); preload(32'd1); preload(32'd33);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'hC);
    bus.op_valid = 1'b1;
    bus.op_code  = 4'b1100;
    tick();
    check("b2b_c1_ready",  {31'b0, bus.op_ready}, 32'h0);
    tick();
    tick();
    tick();
    check("b2b_c4_ready",  {31'b0, bus.op_ready},  32'h0);
    check("b2b_c4_done",   {31'b0, bus.done},      32'h1);
    check("b2b_c4_data",   bus.stack_push_data,    32'h2);
    tick();
    check("b2b_c5_ready",  {31'b0, bus.op_ready},  32'h1);
    check("b2b_c5_state",  {29'b0, dbg_state},     32'h0);
    tick();
    bus.op_valid = 1'b0;
    check("b2b_c6_state",  {29'b0, dbg_state},     32'h1);
    check("b2b_c6_pop",    {31'b0, bus.stack_pop}, 32'h1);
    check("b2b_c6_ready",  {31'b0, bus.op_ready},  32'h0);
    tick();
    tick();
    check("b2b_c8_opa",    bus.alu_operand_a,      32'd3);
    check("b2b_c8_opb",    bus.alu_operand_b,      32'd2);
    tick();
    check("b2b_c9_done",   {31'b0, bus.done},      32'h1);
    check("b2b_c9_data",   bus.stack_push_data,    32'hC);
    tick();
    check("b2b_c10_ready", {31'b0, bus.op_ready},  32'h1);
    check("b2b_depth",     {27'b0, sp},            32'h1);
    check("b2b_result",    mem[0],                 32'hC);

    tick();
    check("sb_drained", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
